// File: rtl/lpm_server_if.sv
// LpmRequest (enter/write) and indication (done) method bundle between the host and lpm_server.
// Master drives method enables and data; slave returns ready and the lookup result.
interface lpm_server_if;
   logic        enter__ENA;
   logic [31:0] enter_data;
   logic        enter__RDY;
   logic        write__ENA;
   logic [31:0] write_addr;
   logic [31:0] write_data;
   logic        write__RDY;
   logic        done__ENA;
   logic [31:0] done_data;
   logic        done__RDY;

   modport master (
      output enter__ENA, enter_data, write__ENA, write_addr, write_data, done__RDY,
      input  enter__RDY, write__RDY, done__ENA, done_data
   );

   modport slave (
      input  enter__ENA, enter_data, write__ENA, write_addr, write_data, done__RDY,
      output enter__RDY, write__RDY, done__ENA, done_data
   );
endinterface

// File: rtl/lpm_server.sv
// Longest-prefix-match trie walker: one STRIDE-bit key chunk per level over a 2^ADDR_WIDTH x 32 table.
// Latency: done rises 2*(L+1)+1 edges after enter for a lookup resolving at level L; one lookup in flight.
// Backpressure: done/data held until done__RDY; enter blocked until then. Optional LPM_STATS_EN adds counters.
module lpm_server #(
   parameter int ADDR_WIDTH = 10,
   parameter int STRIDE     = 8
) (
   input  logic CLK,
   input  logic nRST,
   lpm_server_if.slave bus
`ifdef LPM_STATS_EN
   ,
   output logic [31:0] stats_lookups,
   output logic [31:0] stats_misses
`endif
);
   localparam int DEPTH  = 1 << ADDR_WIDTH;
   localparam int LEVELS = 32 / STRIDE;
   localparam int LVL_W  = (LEVELS > 1) ? $clog2(LEVELS) : 1;

   typedef enum logic [1:0] {IDLE, READ, CHECK, RESP} state_t;

   state_t                  state;
   logic [LVL_W-1:0]        level;
   logic [ADDR_WIDTH-1:0]   addr;
   logic [31:0]             key_q;
   logic [31:0]             rd_data;
   logic                    enter_rdy;
   logic                    write_rdy;
   logic                    done_ena;
   logic [31:0]             done_dat;
   logic [31:0]             table_mem [0:DEPTH-1];

   logic enter_fire;
   logic write_fire;
   logic done_fire;
   logic unused_addr_bits;

   assign enter_fire       = bus.enter__ENA && enter_rdy;
   assign write_fire       = bus.write__ENA && write_rdy;
   assign done_fire        = done_ena && bus.done__RDY;
   assign unused_addr_bits = ^bus.write_addr[31:ADDR_WIDTH];

   assign bus.enter__RDY = enter_rdy;
   assign bus.write__RDY = write_rdy;
   assign bus.done__ENA  = done_ena;
   assign bus.done_data  = done_dat;

   // Writes only fire in IDLE/RESP and reads only in READ, so the ports never collide.
   always_ff @(posedge CLK) begin
      if (write_fire)
         table_mem[bus.write_addr[ADDR_WIDTH-1:0]] <= bus.write_data;
      if (state == READ)
         rd_data <= table_mem[addr];
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state     <= IDLE;
         level     <= '0;
         addr      <= '0;
         key_q     <= '0;
         enter_rdy <= 1'b1;
         write_rdy <= 1'b1;
         done_ena  <= 1'b0;
         done_dat  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (enter_fire) begin
                  // key_q is pre-shifted so its top chunk is always the next level's chunk
                  addr      <= ADDR_WIDTH'(bus.enter_data[31 -: STRIDE]);
                  key_q     <= bus.enter_data << STRIDE;
                  level     <= '0;
                  enter_rdy <= 1'b0;
                  write_rdy <= 1'b0;
                  state     <= READ;
               end
            end
            READ: begin
               state <= CHECK;
            end
            CHECK: begin
               if (rd_data[31]) begin
                  done_dat  <= {1'b1, rd_data[30:0]};
                  write_rdy <= 1'b1;
                  state     <= RESP;
               end else if (level == LVL_W'(LEVELS - 1)) begin
                  done_dat  <= '0;
                  write_rdy <= 1'b1;
                  state     <= RESP;
               end else begin
                  level <= level + LVL_W'(1);
                  addr  <= rd_data[ADDR_WIDTH-1:0] + ADDR_WIDTH'(key_q[31 -: STRIDE]);
                  key_q <= key_q << STRIDE;
                  state <= READ;
               end
            end
            RESP: begin
               if (done_fire) begin
                  done_ena  <= 1'b0;
                  enter_rdy <= 1'b1;
                  state     <= IDLE;
               end else begin
                  done_ena <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef LPM_STATS_EN
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         stats_lookups <= '0;
         stats_misses  <= '0;
      end else if (done_fire) begin
         stats_lookups <= stats_lookups + 32'd1;
         if (!done_dat[31])
            stats_misses <= stats_misses + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_lpm_server.sv
// Randomized bench for lpm_server against a table-walk reference model; LPM_STATS_EN also checks counters.
module tb_lpm_server;
   localparam int AW    = 10;
   localparam int ST    = 8;
   localparam int LV    = 32 / ST;
   localparam int DEPTH = 1 << AW;

   logic clk  = 1'b0;
   logic nrst = 1'b0;

   lpm_server_if bus();

`ifdef LPM_STATS_EN
   logic [31:0] st_lookups;
   logic [31:0] st_misses;
`endif

   lpm_server #(.ADDR_WIDTH(AW), .STRIDE(ST)) dut (
      .CLK  (clk),
      .nRST (nrst),
      .bus  (bus)
`ifdef LPM_STATS_EN
      ,
      .stats_lookups (st_lookups),
      .stats_misses  (st_misses)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int exp_lookups = 0;
   int exp_misses  = 0;
   logic [31:0] tbl [DEPTH];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Walk the trie on the model table; returns result and the level at which it resolved.
   function automatic void model(input logic [31:0] key, output logic [31:0] res, output int lvl);
      int          a;
      int          chunk;
      logic [31:0] e;
      bit          found;
      res = 32'h0; lvl = LV - 1; found = 0; a = 0; e = 32'h0;
      for (int l = 0; l < LV; l++) begin
         if (!found) begin
            chunk = int'((key >> (32 - (l + 1) * ST)) & ((32'd1 << ST) - 32'd1));
            a = (l == 0) ? chunk : (int'(e[AW-1:0]) + chunk) % DEPTH;
            e = tbl[a];
            if (e[31]) begin
               res = {1'b1, e[30:0]};
               lvl = l;
               found = 1;
            end
         end
      end
   endfunction

   task automatic wr(input logic [31:0] addr, input logic [31:0] data);
      bus.write__ENA = 1'b1; bus.write_addr = addr; bus.write_data = data;
      @(posedge clk);
      tbl[addr[AW-1:0]] = data;
      #1 bus.write__ENA = 1'b0;
      @(negedge clk);
   endtask

   task automatic lookup(input string tag, input logic [31:0] key, input bit coll,
                         input logic [31:0] waddr, input logic [31:0] wdata, input int hold);
      logic [31:0] exp_res;
      logic [31:0] held;
      int          exp_lvl;
      int          k;
      chk({tag, " enter_rdy idle"}, {31'b0, bus.enter__RDY}, 32'd1);
      bus.enter__ENA = 1'b1; bus.enter_data = key;
      if (coll) begin
         bus.write__ENA = 1'b1; bus.write_addr = waddr; bus.write_data = wdata;
         tbl[waddr[AW-1:0]] = wdata;
      end
      model(key, exp_res, exp_lvl);
      @(posedge clk);
      #1 bus.enter__ENA = 1'b0; bus.write__ENA = 1'b0;
      @(negedge clk);
      chk({tag, " write_rdy busy"}, {31'b0, bus.write__RDY}, 32'd0);
      k = 0;
      while (!bus.done__ENA && k < 40) begin
         @(posedge clk); k++; @(negedge clk);
      end
      chk({tag, " latency"}, k, 2 * (exp_lvl + 1) + 1);
      chk({tag, " data"}, bus.done_data, exp_res);
      held = bus.done_data;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); @(negedge clk);
         chk({tag, " hold ena"}, {31'b0, bus.done__ENA}, 32'd1);
         chk({tag, " hold data"}, bus.done_data, held);
         chk({tag, " hold enter_rdy"}, {31'b0, bus.enter__RDY}, 32'd0);
         chk({tag, " hold write_rdy"}, {31'b0, bus.write__RDY}, 32'd1);
      end
      bus.done__RDY = 1'b1;
      @(posedge clk);
      #1 bus.done__RDY = 1'b0;
      exp_lookups++;
      if (!exp_res[31]) exp_misses++;
      @(negedge clk);
      chk({tag, " done drop"}, {31'b0, bus.done__ENA}, 32'd0);
      chk({tag, " enter_rdy after"}, {31'b0, bus.enter__RDY}, 32'd1);
`ifdef LPM_STATS_EN
      chk({tag, " stats lookups"}, st_lookups, exp_lookups);
      chk({tag, " stats misses"}, st_misses, exp_misses);
`endif
   endtask

   task automatic reset_checks(input string tag);
      chk({tag, " enter_rdy"}, {31'b0, bus.enter__RDY}, 32'd1);
      chk({tag, " write_rdy"}, {31'b0, bus.write__RDY}, 32'd1);
      chk({tag, " done_ena"}, {31'b0, bus.done__ENA}, 32'd0);
      chk({tag, " done_data"}, bus.done_data, 32'd0);
`ifdef LPM_STATS_EN
      chk({tag, " stats lookups"}, st_lookups, 32'd0);
      chk({tag, " stats misses"}, st_misses, 32'd0);
`endif
   endtask

   initial begin
      logic [31:0] key;
      logic [31:0] data;
      bus.enter__ENA = 1'b0; bus.enter_data = '0;
      bus.write__ENA = 1'b0; bus.write_addr = '0; bus.write_data = '0;
      bus.done__RDY  = 1'b0;
      nrst = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_checks("in reset");
      nrst = 1'b1;
      @(negedge clk);
      reset_checks("after reset");

      for (int i = 0; i < DEPTH; i++) wr(i, 32'h0);

      wr(32'h0A, 32'h8000_1234);
      lookup("leaf l0", 32'h0A00_0000, 0, 0, 0, 0);

      wr(32'h0A, 32'h0000_0100);
      wr(32'h10B, 32'h8000_0055);
      lookup("two level", 32'h0A0B_0000, 0, 0, 0, 0);

      wr(32'h10B, 32'h0000_0200);
      wr(32'h20C, 32'h0000_0300);
      wr(32'h30D, 32'h0000_0000);
      lookup("full miss", 32'h0A0B_0C0D, 0, 0, 0, 0);
      lookup("backpressure", 32'h0A0B_0C0D, 0, 0, 0, 5);
      lookup("collision", 32'h0A00_0000, 1, 32'h0A, 32'h8000_0077, 0);

      // Reset arrives while the walk is in CHECK.
      wr(32'h0A, 32'h0000_0100);
      bus.enter__ENA = 1'b1; bus.enter_data = 32'h0A0B_0C0D;
      @(posedge clk);
      #1 bus.enter__ENA = 1'b0;
      @(posedge clk);
      @(negedge clk);
      nrst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      nrst = 1'b1;
      exp_lookups = 0; exp_misses = 0;
      reset_checks("mid reset");
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); @(negedge clk);
         chk("no done after reset", {31'b0, bus.done__ENA}, 32'd0);
      end
      wr(32'hFFFF_F40A, 32'h8000_4321);
      lookup("post reset", 32'h0A77_0000, 0, 0, 0, 2);

      for (int n = 0; n < 60; n++) begin
         for (int w = 0; w < int'($urandom_range(0, 4)); w++) begin
            data = $urandom;
            if ($urandom_range(0, 9) < 4) data[31] = 1'b1;
            else data[31] = 1'b0;
            wr($urandom, data);
         end
         key  = $urandom;
         data = $urandom;
         lookup("random", key, ($urandom_range(0, 3) == 0), $urandom, data,
                int'($urandom_range(0, 3)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
